fsm_table: RTL and testbench

- Parametrised, table-driven Moore state-machine core; successor to the fixed single-rule FSM/FSMLogic pair.
- Transition rules arrive as packed input vectors, so one instance covers any small controller.
- Adds over the previous generation:
  - NUM_RULES prioritised rules.
  - Selectable hold-vs-default fallback.
  - Enable/stall.
  - Previous-state tracking, transition strobe, per-state dwell counter.
- Sits inside decode/control blocks; rule vectors are normally tied to constants by the parent.

---
 rtl/fsm_table_pkg.sv | 27 ++
 rtl/fsm_table_next_state.sv | 84 ++++++++
 rtl/fsm_table.sv | 116 +++++++++++
 tb/tb_fsm_table.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_table_pkg.sv
// Shared types and helpers for the table-driven Moore FSM core (fsm_table).
// The optional timeout path is enabled with FSM_TIMEOUT_EN.
package fsm_table_pkg;

  localparam int RULE_VEC_MAX   = 256;
  localparam int RULE_FIELD_MAX = 32;

  // All-ones ceiling; users truncate it to their own dwell width.
  localparam logic [63:0] DWELL_MAX = '1;

  typedef enum logic [1:0] {
    SRC_FALLBACK,
    SRC_RULE,
    SRC_TIMEOUT
  } ns_src_e;

  function automatic logic [RULE_FIELD_MAX-1:0] rule_field(
    input logic [RULE_VEC_MAX-1:0] vec,
    input int unsigned             idx,
    input int unsigned             w
  );
    logic [RULE_VEC_MAX-1:0] mask;
    mask = (RULE_VEC_MAX'(1) << w) - RULE_VEC_MAX'(1);
    return RULE_FIELD_MAX'((vec >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/fsm_table_next_state.sv
// Combinational next-state logic: prioritised rule match, optional timeout, fallback.
// Timeout inputs/select exist only when FSM_TIMEOUT_EN is defined.
module fsm_table_next_state
  import fsm_table_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter int NUM_RULES    = 2,
`ifdef FSM_TIMEOUT_EN
  parameter int DWELL_W      = 8,
`endif
  parameter int DEFAULT_HOLD = 0
) (
  input  logic [STATE_W-1:0]           state_i,
  input  logic [STATE_W-1:0]           default_state_i,
  input  logic [NUM_RULES*STATE_W-1:0] rule_from_i,
  input  logic [NUM_RULES*STATE_W-1:0] rule_to_i,
  input  logic [NUM_RULES-1:0]         rule_cond_i,
`ifdef FSM_TIMEOUT_EN
  input  logic [DWELL_W-1:0]           dwell_i,
  input  logic [DWELL_W-1:0]           timeout_limit_i,
  input  logic [STATE_W-1:0]           timeout_state_i,
  output logic                         timeout_sel_o,
`endif
  output logic [STATE_W-1:0]           next_state_o,
  output logic [NUM_RULES-1:0]         rule_hit_o
);

  logic [RULE_VEC_MAX-1:0] from_ext;
  logic [RULE_VEC_MAX-1:0] to_ext;
  logic [NUM_RULES-1:0]    match;
  logic [STATE_W-1:0]      to_f [NUM_RULES];
  logic [STATE_W-1:0]      rule_tgt;
  logic [STATE_W-1:0]      fallback;
  ns_src_e                 src;

  assign from_ext = RULE_VEC_MAX'(rule_from_i);
  assign to_ext   = RULE_VEC_MAX'(rule_to_i);

  for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
    logic [STATE_W-1:0] from_f;
    assign from_f    = STATE_W'(rule_field(from_ext, gi, STATE_W));
    assign to_f[gi]  = STATE_W'(rule_field(to_ext, gi, STATE_W));
    assign match[gi] = (state_i == from_f) && rule_cond_i[gi];
  end

  // Isolate the lowest set bit: lowest-index rule wins.
  assign rule_hit_o = match & (~match + NUM_RULES'(1));
  assign fallback   = (DEFAULT_HOLD != 0) ? state_i : default_state_i;

  always_comb begin
    rule_tgt = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rule_hit_o[i]) rule_tgt = rule_tgt | to_f[i];
    end
  end

  always_comb begin
    src = SRC_FALLBACK;
    if (|match) begin
      src = SRC_RULE;
    end
`ifdef FSM_TIMEOUT_EN
    else if ((timeout_limit_i != '0) && (dwell_i >= timeout_limit_i)) begin
      src = SRC_TIMEOUT;
    end
`endif
  end

  always_comb begin
    next_state_o = fallback;
    case (src)
      SRC_RULE:    next_state_o = rule_tgt;
`ifdef FSM_TIMEOUT_EN
      SRC_TIMEOUT: next_state_o = timeout_state_i;
`endif
      default:     next_state_o = fallback;
    endcase
  end

`ifdef FSM_TIMEOUT_EN
  assign timeout_sel_o = (src == SRC_TIMEOUT);
`endif

endmodule

// File: rtl/fsm_table.sv
// Table-driven Moore FSM core: state/prev_state/transition/dwell registers.
// Define FSM_TIMEOUT_EN to add the dwell timeout inputs and timeout_flag output.
module fsm_table
  import fsm_table_pkg::*;
#(
  parameter int                 STATE_W      = 4,
  parameter int                 NUM_RULES    = 2,
  parameter logic [STATE_W-1:0] RESET_STATE  = 4'hb,
  parameter int                 DEFAULT_HOLD = 0,
  parameter int                 DWELL_W      = 8
) (
  input  logic                         clock_port,
  input  logic                         reset_port,
  input  logic                         enable,
  input  logic [STATE_W-1:0]           default_state,
  input  logic [NUM_RULES*STATE_W-1:0] rule_from,
  input  logic [NUM_RULES*STATE_W-1:0] rule_to,
  input  logic [NUM_RULES-1:0]         rule_cond,
`ifdef FSM_TIMEOUT_EN
  input  logic [DWELL_W-1:0]           timeout_limit,
  input  logic [STATE_W-1:0]           timeout_state,
  output logic                         timeout_flag,
`endif
  output logic [STATE_W-1:0]           state,
  output logic [STATE_W-1:0]           next_state,
  output logic [STATE_W-1:0]           prev_state,
  output logic                         transition,
  output logic [NUM_RULES-1:0]         rule_hit,
  output logic [DWELL_W-1:0]           dwell
);

  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(DWELL_MAX);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               trans_q, trans_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               tsel;

  fsm_table_next_state #(
    .STATE_W      (STATE_W),
    .NUM_RULES    (NUM_RULES),
`ifdef FSM_TIMEOUT_EN
    .DWELL_W      (DWELL_W),
`endif
    .DEFAULT_HOLD (DEFAULT_HOLD)
  ) u_next (
    .state_i         (state_q),
    .default_state_i (default_state),
    .rule_from_i     (rule_from),
    .rule_to_i       (rule_to),
    .rule_cond_i     (rule_cond),
`ifdef FSM_TIMEOUT_EN
    .dwell_i         (dwell_q),
    .timeout_limit_i (timeout_limit),
    .timeout_state_i (timeout_state),
    .timeout_sel_o   (tsel),
`endif
    .next_state_o    (next_state),
    .rule_hit_o      (rule_hit)
  );

`ifndef FSM_TIMEOUT_EN
  assign tsel = 1'b0;
`endif

  // A self-loop is "no change": dwell keeps counting and no pulse is raised.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    trans_d = 1'b0;
    dwell_d = dwell_q;
    if (enable) begin
      state_d = next_state;
      if (next_state != state_q) begin
        prev_d  = state_q;
        trans_d = 1'b1;
        dwell_d = '0;
      end else if (dwell_q != DWELL_SAT) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      state_q <= RESET_STATE;
      prev_q  <= RESET_STATE;
      trans_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      trans_q <= trans_d;
      dwell_q <= dwell_d;
    end
  end

`ifdef FSM_TIMEOUT_EN
  logic tflag_q;
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) tflag_q <= 1'b0;
    else             tflag_q <= enable && tsel;
  end
  assign timeout_flag = tflag_q;
`else
  logic unused_tsel;
  assign unused_tsel = tsel;
`endif

  assign state      = state_q;
  assign prev_state = prev_q;
  assign transition = trans_q;
  assign dwell      = dwell_q;

endmodule

// File: tb/tb_fsm_table.sv
// Scoreboard bench for fsm_table: two instances (fallback-to-default and hold)
// share random and directed stimulus; a rule-level reference model predicts outputs.
module tb_fsm_table;

  localparam int             SW     = 4;
  localparam int             NR     = 2;
  localparam int             DW     = 4;
  localparam logic [SW-1:0]  RST_ST = 4'hb;
  localparam logic [DW-1:0]  DW_MAX = 4'hf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1;
  logic              en;
  logic [SW-1:0]     def_st;
  logic [NR*SW-1:0]  rule_from, rule_to;
  logic [NR-1:0]     rule_cond;
  logic [SW-1:0]     st [2];
  logic [SW-1:0]     ns [2];
  logic [SW-1:0]     pv [2];
  logic              tr [2];
  logic [NR-1:0]     hit [2];
  logic [DW-1:0]     dw [2];
`ifdef FSM_TIMEOUT_EN
  logic [DW-1:0]     tlim;
  logic [SW-1:0]     tst;
  logic              tf [2];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fsm_table #(
      .STATE_W(SW), .NUM_RULES(NR), .RESET_STATE(RST_ST),
      .DEFAULT_HOLD(gi), .DWELL_W(DW)
    ) u_dut (
      .clock_port    (clk),
      .reset_port    (rst_n),
      .enable        (en),
      .default_state (def_st),
      .rule_from     (rule_from),
      .rule_to       (rule_to),
      .rule_cond     (rule_cond),
`ifdef FSM_TIMEOUT_EN
      .timeout_limit (tlim),
      .timeout_state (tst),
      .timeout_flag  (tf[gi]),
`endif
      .state         (st[gi]),
      .next_state    (ns[gi]),
      .prev_state    (pv[gi]),
      .transition    (tr[gi]),
      .rule_hit      (hit[gi]),
      .dwell         (dw[gi])
    );
  end

  typedef struct {
    int            id;
    int            k;
    logic [SW-1:0] st, ns, pv;
    logic          tr;
    logic [NR-1:0] hit;
    logic [DW-1:0] dw;
`ifdef FSM_TIMEOUT_EN
    logic          tf;
`endif
  } exp_t;

  exp_t sb[$];
  int   n_cmp, n_bad, txn;

  // Stimulus staging, applied to the DUT inside step()
  logic          d_rst, d_en;
  logic [SW-1:0] d_def;
  logic [NR-1:0] d_cond;
  logic [SW-1:0] r_from [NR];
  logic [SW-1:0] r_to [NR];
`ifdef FSM_TIMEOUT_EN
  logic [DW-1:0] d_tlim;
  logic [SW-1:0] d_tst;
`endif

  // Reference model: registered values currently visible for each instance
  logic [SW-1:0] m_st [2];
  logic [SW-1:0] m_pv [2];
  logic          m_tr [2];
  logic [DW-1:0] m_dw [2];
`ifdef FSM_TIMEOUT_EN
  logic          m_tf [2];
`endif

  task automatic model_reset(input int k);
    m_st[k] = RST_ST;
    m_pv[k] = RST_ST;
    m_tr[k] = 1'b0;
    m_dw[k] = '0;
`ifdef FSM_TIMEOUT_EN
    m_tf[k] = 1'b0;
`endif
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #2;
    rst_n     = d_rst;
    en        = d_en;
    def_st    = d_def;
    rule_cond = d_cond;
    for (int i = 0; i < NR; i++) begin
      rule_from[i*SW +: SW] = r_from[i];
      rule_to[i*SW +: SW]   = r_to[i];
    end
`ifdef FSM_TIMEOUT_EN
    tlim = d_tlim;
    tst  = d_tst;
`endif
    for (int k = 0; k < 2; k++) begin
      int            w;
      logic [SW-1:0] nxt;
      logic          tsel;
      if (!d_rst) model_reset(k);
      w = -1;
      for (int i = 0; i < NR; i++)
        if (w < 0 && r_from[i] == m_st[k] && d_cond[i]) w = i;
      tsel = 1'b0;
      if (w >= 0) nxt = r_to[w];
`ifdef FSM_TIMEOUT_EN
      else if (d_tlim != 0 && m_dw[k] >= d_tlim) begin
        nxt  = d_tst;
        tsel = 1'b1;
      end
`endif
      else nxt = (k == 1) ? m_st[k] : d_def;
      e.id  = txn;
      e.k   = k;
      e.st  = m_st[k];
      e.pv  = m_pv[k];
      e.tr  = m_tr[k];
      e.dw  = m_dw[k];
      e.ns  = nxt;
      e.hit = (w >= 0) ? NR'(1 << w) : '0;
`ifdef FSM_TIMEOUT_EN
      e.tf  = m_tf[k];
`endif
      sb.push_back(e);
      if (d_rst) begin
        if (d_en) begin
          if (nxt != m_st[k]) begin
            m_pv[k] = m_st[k];
            m_tr[k] = 1'b1;
            m_dw[k] = '0;
          end else begin
            m_tr[k] = 1'b0;
            if (m_dw[k] != DW_MAX) m_dw[k] = m_dw[k] + 1'b1;
          end
          m_st[k] = nxt;
`ifdef FSM_TIMEOUT_EN
          m_tf[k] = tsel;
`endif
        end else begin
          m_tr[k] = 1'b0;
`ifdef FSM_TIMEOUT_EN
          m_tf[k] = 1'b0;
`endif
        end
      end
    end
    txn++;
  endtask

  task automatic chk(input string nm, input int id, input int k,
                     input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL txn %0d dut%0d %s: got %h expected %h", id, k, nm, act, exp_v);
    end
  endtask

  // Monitor: every negedge the DUTs present one transaction each
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state",      e.id, e.k, 8'(st[e.k]),  8'(e.st));
        chk("next_state", e.id, e.k, 8'(ns[e.k]),  8'(e.ns));
        chk("prev_state", e.id, e.k, 8'(pv[e.k]),  8'(e.pv));
        chk("transition", e.id, e.k, 8'(tr[e.k]),  8'(e.tr));
        chk("rule_hit",   e.id, e.k, 8'(hit[e.k]), 8'(e.hit));
        chk("dwell",      e.id, e.k, 8'(dw[e.k]),  8'(e.dw));
`ifdef FSM_TIMEOUT_EN
        chk("timeout_flag", e.id, e.k, 8'(tf[e.k]), 8'(e.tf));
`endif
        $display("txn %0d dut%0d state=%h next=%h prev=%h trans=%b hit=%b dwell=%0d",
                 e.id, e.k, st[e.k], ns[e.k], pv[e.k], tr[e.k], hit[e.k], dw[e.k]);
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; txn = 0;
    en = 1'b1; def_st = '0; rule_from = '0; rule_to = '0; rule_cond = '0;
`ifdef FSM_TIMEOUT_EN
    tlim = '0; tst = '0; d_tlim = '0; d_tst = '0;
`endif
    rst_n = 1'b0;
    d_rst = 1'b0; d_en = 1'b1; d_def = '0; d_cond = '0;
    for (int i = 0; i < NR; i++) begin r_from[i] = '0; r_to[i] = '0; end
    model_reset(0);
    model_reset(1);

    // b->c on cond, b->b on !cond, default c
    step();
    d_rst = 1'b1;
    r_from[0] = 4'hb; r_to[0] = 4'hc; r_from[1] = 4'hb; r_to[1] = 4'hb;
    d_def = 4'hc; d_cond = 2'b01;
    repeat (3) step();

    // Self-loop dwell count to 10 and on into saturation
    d_rst = 1'b0; step(); d_rst = 1'b1;
    d_cond = 2'b10;
    repeat (18) step();

    // Both rules match from b: rule 0 wins
    r_to[0] = 4'h3; r_to[1] = 4'h5; d_cond = 2'b11;
    repeat (2) step();

    // Stall while a rule matches
    d_rst = 1'b0; step(); d_rst = 1'b1;
    d_en = 1'b0;
    repeat (4) step();
    d_en = 1'b1;
    repeat (2) step();

`ifdef FSM_TIMEOUT_EN
    // Timeout to state 2 with no matching rule, then async reset mid-count
    d_rst = 1'b0; step(); d_rst = 1'b1;
    r_from[0] = 4'h0; r_from[1] = 4'h0; d_cond = 2'b00; d_def = 4'hb;
    d_tlim = 4'd5; d_tst = 4'h2;
    repeat (9) step();
    d_rst = 1'b0; step(); d_rst = 1'b1;
    repeat (3) step();
    d_rst = 1'b0; step(); d_rst = 1'b1;
    step();
`endif

    repeat (200) begin
      d_rst = ($urandom_range(0, 39) != 0);
      d_en  = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < NR; i++) begin
        r_from[i] = ($urandom_range(0, 1) == 0) ? m_st[$urandom_range(0, 1)] : 4'($urandom);
        r_to[i]   = ($urandom_range(0, 3) == 0) ? r_from[i] : 4'($urandom);
      end
      d_cond = 2'($urandom);
      d_def  = ($urandom_range(0, 2) == 0) ? m_st[0] : 4'($urandom);
`ifdef FSM_TIMEOUT_EN
      d_tlim = 4'($urandom_range(0, 6));
      d_tst  = ($urandom_range(0, 2) == 0) ? m_st[1] : 4'($urandom);
`endif
      step();
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
